// File: rtl/decode_stage.sv
// Registered, handshaked decode stage with a WFI/ISR state machine and nesting tracker.
// Define DECODE_SKID_EN for a one-entry skid buffer with a registered in_ready.
module decode_stage #(
  parameter int unsigned LIT_W    = 11,
  parameter int unsigned NEST_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [LIT_W-1:0] in_lit,
  input  logic             irq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       pc_mux,
  output logic             pc_save,
  output logic [1:0]       w_mux,
  output logic             mem_write,
  output logic [3:0]       alu_op,
  output logic [LIT_W-1:0] out_lit,
  output logic [1:0]       state,
  output logic             nest_err
);

  localparam int unsigned   DW        = $clog2(NEST_MAX + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(NEST_MAX);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

  localparam logic [1:0] PC_ADD = 2'd0, PC_WREG = 2'd1, PC_LIT = 2'd2, PC_SAVE = 2'd3;
  localparam logic [1:0] W_ALU  = 2'd0, W_MEM   = 2'd1, W_LIT  = 2'd2, W_WREG  = 2'd3;
  localparam logic [3:0] ALU_ROTL = 4'h0, ALU_ROTR = 4'h1, ALU_ADD = 4'h2, ALU_SUB = 4'h3,
                         ALU_AND  = 4'h4, ALU_OR   = 4'h5, ALU_XOR = 4'h6, ALU_ZEROT = 4'h7,
                         ALU_PCZ  = 4'h8, ALU_PCZB = 4'h9, ALU_NOP = 4'hA;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ISR  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] pc_mux;
    logic       pc_save;
    logic [1:0] w_mux;
    logic       mem_write;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{pc_mux: PC_ADD, pc_save: 1'b0, w_mux: W_WREG,
                                 mem_write: 1'b0, alu_op: ALU_NOP};

  state_e            state_q, state_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              out_valid_q, out_valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [LIT_W-1:0]  lit_q, lit_d;
  logic              nest_err_q, nest_err_d;

  logic              load;
  logic [4:0]        ld_opcode;
  logic [LIT_W-1:0]  ld_lit;
  ctrl_t             dec_ctrl;
  logic              dec_wfi, dec_rfi, dec_err, alu_grp;

`ifdef DECODE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [4:0]        skid_op_q, skid_op_d;
  logic [LIT_W-1:0]  skid_lit_q, skid_lit_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, can_load;

  // The skid entry always drains first so instructions stay in order; nothing
  // issues while waiting for an interrupt, even from the buffer.
  always_comb begin
    can_load     = (~out_valid_q | out_ready) & (state_q != ST_WAIT);
    accept       = in_valid & in_ready_q;
    load         = can_load & (skid_valid_q | accept);
    ld_opcode    = skid_valid_q ? skid_op_q  : in_opcode;
    ld_lit       = skid_valid_q ? skid_lit_q : in_lit;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_lit_d   = skid_lit_q;
    if (skid_valid_q) begin
      if (load) skid_valid_d = 1'b0;
    end else if (accept & ~load) begin
      skid_valid_d = 1'b1;
      skid_op_d    = in_opcode;
      skid_lit_d   = in_lit;
    end
    in_ready_d = ~skid_valid_d & (state_d != ST_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_op_q    <= '0;
      skid_lit_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_lit_q   <= skid_lit_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  always_comb begin
    load      = in_valid & in_ready;
    ld_opcode = in_opcode;
    ld_lit    = in_lit;
  end
`endif

  // Decode of the instruction entering the output register this cycle.
  always_comb begin
    dec_ctrl = CTRL_NOP;
    dec_wfi  = 1'b0;
    dec_rfi  = 1'b0;
    dec_err  = 1'b0;
    alu_grp  = 1'b0;
    case (ld_opcode[4:1])
      4'h0: begin alu_grp = 1'b1; dec_ctrl.alu_op = ALU_ZEROT; dec_ctrl.w_mux = W_MEM; end
      4'h1: dec_ctrl.mem_write = 1'b1;
      4'h2: dec_ctrl.w_mux = W_LIT;
      4'h3: begin alu_grp = 1'b1; dec_ctrl.alu_op = ALU_ROTL; dec_ctrl.w_mux = W_ALU; end
      4'h4: begin alu_grp = 1'b1; dec_ctrl.alu_op = ALU_ROTR; dec_ctrl.w_mux = W_ALU; end
      4'h5: begin alu_grp = 1'b1; dec_ctrl.alu_op = ALU_AND;  dec_ctrl.w_mux = W_ALU; end
      4'h6: begin alu_grp = 1'b1; dec_ctrl.alu_op = ALU_OR;   dec_ctrl.w_mux = W_ALU; end
      4'h7: begin alu_grp = 1'b1; dec_ctrl.alu_op = ALU_XOR;  dec_ctrl.w_mux = W_ALU; end
      4'h8: begin alu_grp = 1'b1; dec_ctrl.alu_op = ALU_ADD;  dec_ctrl.w_mux = W_ALU; end
      4'h9: begin alu_grp = 1'b1; dec_ctrl.alu_op = ALU_SUB;  dec_ctrl.w_mux = W_ALU; end
      4'hA: dec_ctrl.alu_op = ALU_PCZ;
      4'hB: dec_ctrl.alu_op = ALU_PCZB;
      4'hC: dec_ctrl.pc_mux = PC_LIT;
      4'hD: dec_ctrl.pc_mux = PC_WREG;
      4'hE: begin
        if (depth_q == DEPTH_MAX) begin
          dec_err = 1'b1;
        end else begin
          dec_wfi          = 1'b1;
          dec_ctrl.pc_mux  = PC_SAVE;
          dec_ctrl.pc_save = 1'b1;
        end
      end
      4'hF: begin
        if (depth_q == '0) begin
          dec_err = 1'b1;
        end else begin
          dec_rfi         = 1'b1;
          dec_ctrl.pc_mux = PC_SAVE;
        end
      end
      default: ;
    endcase
    if (alu_grp & ld_opcode[0]) begin
      dec_ctrl.w_mux     = W_WREG;
      dec_ctrl.mem_write = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    if (state_q == ST_WAIT) begin
      if (irq) state_d = ST_ISR;
    end else if (load) begin
      if (dec_wfi) begin
        state_d = ST_WAIT;
        depth_d = depth_q + DEPTH_ONE;
      end else if (dec_rfi) begin
        depth_d = depth_q - DEPTH_ONE;
        if (depth_q == DEPTH_ONE) state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    state = state_q;
`ifdef DECODE_SKID_EN
    in_ready = in_ready_q;
`else
    in_ready = (state_q != ST_WAIT) & (~out_valid_q | out_ready);
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    lit_d       = lit_q;
    nest_err_d  = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_ctrl;
      lit_d       = ld_lit;
      nest_err_d  = dec_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      lit_q       <= '0;
      nest_err_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      lit_q       <= lit_d;
      nest_err_q  <= nest_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_mux    = ctrl_q.pc_mux;
  assign pc_save   = ctrl_q.pc_save;
  assign w_mux     = ctrl_q.w_mux;
  assign mem_write = ctrl_q.mem_write;
  assign alu_op    = ctrl_q.alu_op;
  assign out_lit   = lit_q;
  assign nest_err  = nest_err_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven reference model compared every cycle,
// plus hand-computed literal expectations at key points.
module tb_decode_stage;
  localparam int LIT_W    = 11;
  localparam int NEST_MAX = 3;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, irq = 1'b0, out_ready = 1'b1;
  logic [4:0]       in_opcode = '0;
  logic [LIT_W-1:0] in_lit = '0;
  logic             in_ready, out_valid, pc_save, mem_write, nest_err;
  logic [1:0]       pc_mux, w_mux, state;
  logic [3:0]       alu_op;
  logic [LIT_W-1:0] out_lit;

  int checks = 0, failures = 0;

  // Opcode-field tables indexed by in_opcode[4:1].
  int alu_of   [16] = '{7, 10, 10, 0, 1, 4, 5, 6, 2, 3, 8, 9, 10, 10, 10, 10};
  int wmux_of  [16] = '{1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3, 3, 3};
  int pcmux_of [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3, 3};

  int m_state, m_depth, m_ov, m_pc, m_ps, m_w, m_mw, m_alu, m_lit, m_err;

  decode_stage #(.LIT_W(LIT_W), .NEST_MAX(NEST_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_lit(in_lit), .irq(irq), .out_valid(out_valid),
    .out_ready(out_ready), .pc_mux(pc_mux), .pc_save(pc_save), .w_mux(w_mux),
    .mem_write(mem_write), .alu_op(alu_op), .out_lit(out_lit), .state(state),
    .nest_err(nest_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_alu_grp(input int op);
    return (op == 0) || (op >= 3 && op <= 9);
  endfunction

  task automatic m_reset();
    m_state = 0; m_depth = 0; m_ov = 0; m_pc = 0; m_ps = 0;
    m_w = 3; m_mw = 0; m_alu = 10; m_lit = 0; m_err = 0;
  endtask

  // Compare DUT against the model mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    int op;
    bit b0, exp_ir, acc, err;
    if (!rst_n) m_reset();
    exp_ir = (m_state != 1) && (m_ov == 0 || out_ready);
    chk("out_valid", out_valid, m_ov);
    chk("in_ready", in_ready, exp_ir);
    chk("state", state, m_state);
    chk("nest_err", nest_err, m_err);
    chk("pc_mux", pc_mux, m_pc);
    chk("pc_save", pc_save, m_ps);
    chk("w_mux", w_mux, m_w);
    chk("mem_write", mem_write, m_mw);
    chk("alu_op", alu_op, m_alu);
    chk("out_lit", out_lit, m_lit);
    if (rst_n) begin
      acc = in_valid && exp_ir;
      err = 0;
      if (m_state == 1 && irq) m_state = 2;
      if (acc) begin
        op    = int'(in_opcode[4:1]);
        b0    = in_opcode[0];
        m_pc  = pcmux_of[op];
        m_ps  = (op == 14);
        m_w   = wmux_of[op];
        m_alu = alu_of[op];
        m_mw  = (op == 1);
        if (is_alu_grp(op) && b0) begin m_w = 3; m_mw = 1; end
        m_lit = int'(in_lit);
        if (op == 14) begin
          if (m_depth == NEST_MAX) err = 1;
          else begin m_depth++; m_state = 1; end
        end else if (op == 15) begin
          if (m_depth == 0) err = 1;
          else begin m_depth--; if (m_depth == 0) m_state = 0; end
        end
        if (err) begin m_pc = 0; m_ps = 0; m_alu = 10; m_w = 3; m_mw = 0; end
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      m_err = err;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [4:0] op, input logic [LIT_W-1:0] lit);
    bit ok = 0;
    int n = 0;
    in_valid = 1'b1; in_opcode = op; in_lit = lit;
    while (!ok && n < 40) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int nacc;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_w_mux", w_mux, 3);
    chk("rst_alu", alu_op, 10);
    chk("rst_state", state, 0);
    rst_n = 1'b1;

    // Stream every non-wfi opcode back to back.
    for (int i = 0; i < 32; i++) begin
      if (i != 28 && i != 29) begin
        send(5'(i), 11'(i * 37));
        if (i == 'h11) begin
          chk("op11_w_mux", w_mux, 3);
          chk("op11_mem_write", mem_write, 1);
          chk("op11_alu", alu_op, 2);
          chk("op11_lit", out_lit, 629);
        end
        if (i == 0) begin
          chk("op00_w_mux", w_mux, 1);
          chk("op00_alu", alu_op, 7);
        end
        if (i == 31) begin
          chk("rfi_run_alu", alu_op, 10);
          chk("rfi_run_pc_mux", pc_mux, 0);
          chk("rfi_run_err", nest_err, 1);
        end
      end
    end
    idle(2);

    // Backpressure: one accepted during a 4-cycle stall, second follows on release.
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 5'h08; in_lit = 11'h055;
    nacc = 0;
    repeat (4) begin
      @(negedge clk); if (in_valid && in_ready) nacc++;
      @(posedge clk); #1;
      if (nacc > 0) begin in_opcode = 5'h0A; in_lit = 11'h066; end
    end
    chk("hold_accepts", nacc, 1);
    chk("hold_lit", out_lit, 11'h055);
    chk("hold_alu", alu_op, 1);
    out_ready = 1'b1;
    send(5'h0A, 11'h066);
    chk("release_lit", out_lit, 11'h066);
    chk("release_alu", alu_op, 4);
    idle(2);

    // wfi then a delayed interrupt.
    send(5'h1C, 11'h100);
    chk("wfi_state", state, 1);
    chk("wfi_pc_mux", pc_mux, 3);
    chk("wfi_pc_save", pc_save, 1);
    repeat (5) begin
      @(negedge clk);
      chk("wait_in_ready", in_ready, 0);
      chk("wait_state", state, 1);
      @(posedge clk); #1;
    end
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    chk("isr_state", state, 2);

    // rfi back to RUN, then an unmatched rfi.
    send(5'h1E, 11'h011);
    chk("rfi_pc_mux", pc_mux, 3);
    chk("rfi_pc_save", pc_save, 0);
    chk("rfi_state", state, 0);
    chk("rfi_err", nest_err, 0);
    send(5'h1F, 11'h012);
    chk("rfi2_alu", alu_op, 10);
    chk("rfi2_err", nest_err, 1);
    idle(1);
    chk("rfi2_err_pulse", nest_err, 0);

    // Nest to the limit, overflow once, unwind.
    for (int k = 0; k < 3; k++) begin
      send((k == 1) ? 5'h1D : 5'h1C, 11'(k));
      chk("nest_wait", state, 1);
      irq = 1'b1;
      @(posedge clk); #1;
      irq = 1'b0;
      chk("nest_isr", state, 2);
    end
    send(5'h1C, 11'h7FF);
    chk("ovf_err", nest_err, 1);
    chk("ovf_alu", alu_op, 10);
    chk("ovf_pc_mux", pc_mux, 0);
    chk("ovf_pc_save", pc_save, 0);
    chk("ovf_state", state, 2);
    for (int k = 0; k < 3; k++) begin
      send(5'h1E, 11'(k + 8));
      chk("unwind_state", state, (k == 2) ? 0 : 2);
    end
    idle(2);

    // Asynchronous reset while waiting with a held output.
    out_ready = 1'b0;
    send(5'h1C, 11'h3AB);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_state", state, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_state", state, 0);
    chk("arst_w_mux", w_mux, 3);
    chk("arst_alu", alu_op, 10);
    chk("arst_pc_mux", pc_mux, 0);
    chk("arst_pc_save", pc_save, 0);
    chk("arst_mem_write", mem_write, 0);
    chk("arst_lit", out_lit, 0);
    chk("arst_err", nest_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_state", state, 0);
    send(5'h05, 11'h123);
    chk("post_rst_w_mux", w_mux, 2);
    chk("post_rst_alu", alu_op, 10);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
